// File: rtl/hs_dpath_ce_chain_sink.sv
// Purpose: credit-managed receive buffer at the tail of a clock-enable chain, re-presented as a valid/ready stream.
// Latency: a word granted at cycle t arrives on ce_in at t+LATENCY and shows on m_valid at t+LATENCY+1.
// Backpressure: m_ready low holds the head word; ce_grant drops once every slot is occupied or reserved in flight.
module hs_dpath_ce_chain_sink #(
   parameter type      DATA_TYPE   = logic,
   parameter DATA_TYPE RESET_VALUE = DATA_TYPE'(1'b0),
   parameter int       DEPTH       = 4,
   parameter int       LATENCY     = 1
) (
   input  logic                       clk,
   input  logic                       aresetn,
   input  logic                       src_req,
   output logic                       ce_grant,
   input  logic                       ce_in,
   input  DATA_TYPE                   din,
   output logic                       m_valid,
   input  logic                       m_ready,
   output DATA_TYPE                   m_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [$clog2(DEPTH+1)-1:0] credits,
   output logic                       overflow
);

   localparam int            CW       = $clog2(DEPTH + 1);
   localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   // LATENCY only shapes the credit loop seen from outside; the buffer itself
   // needs no knowledge of it beyond this sanity check.
   generate
      if (DEPTH < 1 || LATENCY < 1) begin : g_param_check
         $error("hs_dpath_ce_chain_sink: DEPTH and LATENCY must both be at least 1");
      end
   endgenerate

   DATA_TYPE       mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [CW-1:0]  count_q;
   logic [CW-1:0]  credits_q;
   logic           overflow_q;

   logic           pop;
   logic           full;
   logic           push_acc;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // A push is accepted unless the buffer is full with no slot freed this cycle;
   // when full, a simultaneous pop frees the slot the push then lands in.
   assign pop      = m_valid & m_ready;
   assign full     = (count_q == DEPTH_C);
   assign push_acc = ce_in & (~full | pop);

   // The grant is combinational so the non-stallable chain launches only into a reserved slot.
   assign ce_grant = aresetn & src_req & (credits_q != '0);

   assign m_valid  = (count_q != '0);
   assign m_data   = mem[rd_ptr];
   assign count    = count_q;
   assign credits  = credits_q;
   assign overflow = overflow_q;

   // Storage: written only for accepted pushes; no write-to-read bypass.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= RESET_VALUE;
         end
      end else if (push_acc) begin
         mem[wr_ptr] <= din;
      end
   end

   // Write pointer advances on accepted pushes, read pointer on pops.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_acc) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
      end
   end

   // Occupancy tracks accepted pushes minus pops.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         count_q <= '0;
      end else begin
         count_q <= count_q + CW'(push_acc) - CW'(pop);
      end
   end

   // Credits are consumed at grant time and returned at pop time, so a popped slot
   // becomes grantable on the following cycle.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         credits_q <= DEPTH_C;
      end else begin
         credits_q <= credits_q - CW'(ce_grant) + CW'(pop);
      end
   end

   // A word arriving into a full buffer with no pop is dropped and flagged until reset;
   // this only happens if upstream ignored ce_grant or LATENCY is wrong.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         overflow_q <= 1'b0;
      end else if (ce_in && full && !pop) begin
         overflow_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_hs_dpath_ce_chain_sink.sv
// Purpose: randomized and directed checks of hs_dpath_ce_chain_sink against a queue-based model.
// Latency: two instances (DEPTH=4/LATENCY=2 and DEPTH=3/LATENCY=1) are stepped one clock per call.
// Backpressure: m_ready is driven directly; the model chain delivers each granted word LATENCY cycles later.
module tb_hs_dpath_ce_chain_sink;

   localparam int DA = 4, LA = 2, DB = 3, LB = 1;
   typedef logic [7:0] byte_t;
   localparam byte_t RVA = 8'h5A, RVB = 8'h00;
   typedef struct packed { int due; byte_t d; } flight_t;

   logic clk = 1'b0;
   logic aresetn = 1'b0;
   always #5 clk = ~clk;

   logic       src_req_a, ce_in_a, m_ready_a, ce_grant_a, m_valid_a, overflow_a;
   byte_t      din_a, m_data_a;
   logic [2:0] count_a, credits_a;
   logic       src_req_b, ce_in_b, m_ready_b, ce_grant_b, m_valid_b, overflow_b;
   byte_t      din_b, m_data_b;
   logic [1:0] count_b, credits_b;

   hs_dpath_ce_chain_sink #(.DATA_TYPE(byte_t), .RESET_VALUE(RVA), .DEPTH(DA), .LATENCY(LA)) u_a (
      .clk(clk), .aresetn(aresetn), .src_req(src_req_a), .ce_grant(ce_grant_a),
      .ce_in(ce_in_a), .din(din_a), .m_valid(m_valid_a), .m_ready(m_ready_a),
      .m_data(m_data_a), .count(count_a), .credits(credits_a), .overflow(overflow_a));

   hs_dpath_ce_chain_sink #(.DATA_TYPE(byte_t), .RESET_VALUE(RVB), .DEPTH(DB), .LATENCY(LB)) u_b (
      .clk(clk), .aresetn(aresetn), .src_req(src_req_b), .ce_grant(ce_grant_b),
      .ce_in(ce_in_b), .din(din_b), .m_valid(m_valid_b), .m_ready(m_ready_b),
      .m_data(m_data_b), .count(count_b), .credits(credits_b), .overflow(overflow_b));

   int    dep [2]     = '{DA, DB};
   int    lat [2]     = '{LA, LB};
   byte_t rst_val [2] = '{RVA, RVB};
   string nm [2]      = '{"a", "b"};

   // Reference model: stored words, words in flight down the chain, credit and error state.
   byte_t   mq [2][$];
   flight_t fl [2][$];
   int      m_cred [2];
   bit      m_ovf [2];
   byte_t   seq [2];

   bit    s_req [2], s_rdy [2], s_inj [2];
   byte_t inj_dat [2];
   bit    arr [2], cei [2];
   byte_t dii [2];
   int    gcnt [2], max_cnt [2], min_cred [2];
   int    last_cnt [2], last_cred [2], last_ovf [2];
   int    cyc, n_checks, n_fail;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
      end
   endtask

   task automatic drive(input int k, input bit req, input bit rdy, input bit ce, input byte_t d);
      if (k == 0) begin
         src_req_a = req; m_ready_a = rdy; ce_in_a = ce; din_a = d;
      end else begin
         src_req_b = req; m_ready_b = rdy; ce_in_b = ce; din_b = d;
      end
   endtask

   task automatic sample(input int k, output int g, output int v, output int d,
                         output int c, output int cr, output int o);
      if (k == 0) begin
         g = int'(ce_grant_a); v = int'(m_valid_a); d = int'(m_data_a);
         c = int'(count_a); cr = int'(credits_a); o = int'(overflow_a);
      end else begin
         g = int'(ce_grant_b); v = int'(m_valid_b); d = int'(m_data_b);
         c = int'(count_b); cr = int'(credits_b); o = int'(overflow_b);
      end
   endtask

   task automatic stats_clear();
      for (int k = 0; k < 2; k++) begin
         gcnt[k] = 0; max_cnt[k] = 0; min_cred[k] = 99;
      end
   endtask

   // One clock: drive at the falling edge, check #1 later, advance the model at the rising edge.
   task automatic step();
      int g, v, d, c, cr, o;
      bit eg, pop, full;
      for (int k = 0; k < 2; k++) begin
         if (!aresetn) begin
            mq[k].delete(); fl[k].delete(); m_cred[k] = dep[k]; m_ovf[k] = 1'b0;
         end
         arr[k] = aresetn && fl[k].size() != 0 && fl[k][0].due == cyc;
         cei[k] = arr[k] || s_inj[k];
         dii[k] = arr[k] ? fl[k][0].d : inj_dat[k];
         drive(k, s_req[k], s_rdy[k], cei[k], dii[k]);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
         sample(k, g, v, d, c, cr, o);
         eg = aresetn && s_req[k] && m_cred[k] != 0;
         check({nm[k], ".grant"}, g, int'(eg));
         check({nm[k], ".valid"}, v, int'(mq[k].size() != 0));
         if (mq[k].size() != 0) check({nm[k], ".data"}, d, int'(mq[k][0]));
         else if (!aresetn) check({nm[k], ".rst_data"}, d, int'(rst_val[k]));
         check({nm[k], ".count"}, c, mq[k].size());
         check({nm[k], ".credits"}, cr, m_cred[k]);
         check({nm[k], ".overflow"}, o, int'(m_ovf[k]));
         if (g != 0) gcnt[k]++;
         if (c > max_cnt[k]) max_cnt[k] = c;
         if (cr < min_cred[k]) min_cred[k] = cr;
         last_cnt[k] = c; last_cred[k] = cr; last_ovf[k] = o;
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (aresetn) begin
            pop  = mq[k].size() != 0 && s_rdy[k];
            full = mq[k].size() == dep[k];
            eg   = s_req[k] && m_cred[k] != 0;
            if (pop) void'(mq[k].pop_front());
            if (cei[k]) begin
               if (full && !pop) m_ovf[k] = 1'b1;
               else mq[k].push_back(dii[k]);
            end
            if (arr[k]) void'(fl[k].pop_front());
            if (eg) begin
               fl[k].push_back('{due: cyc + lat[k], d: seq[k]});
               seq[k]++;
            end
            m_cred[k] = m_cred[k] - int'(eg) + int'(pop);
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      aresetn = 1'b0;
      step();
      aresetn = 1'b1;
   endtask

   initial begin
      int g, v, d, c, cr, o;
      n_checks = 0; n_fail = 0; cyc = 0;
      seq = '{8'h10, 8'h10};
      s_req = '{0, 0}; s_rdy = '{0, 0}; s_inj = '{0, 0}; inj_dat = '{8'h00, 8'h00};
      for (int k = 0; k < 2; k++) begin
         m_cred[k] = dep[k]; m_ovf[k] = 1'b0;
         drive(k, 1'b0, 1'b0, 1'b0, 8'h00);
      end
      stats_clear();
      @(negedge clk);

      // Reset held with src_req high: no grant, empty, full credits.
      s_req = '{1, 1};
      repeat (3) step();
      aresetn = 1'b1;

      // Full-rate streaming on the DEPTH=3, LATENCY=1 instance.
      s_req = '{0, 1}; s_rdy = '{0, 1};
      stats_clear();
      repeat (30) step();
      check("b.stream_grants", gcnt[1], 30);
      check("b.stream_count_le1", int'(max_cnt[1] <= 1), 1);
      check("b.stream_credits_nz", int'(min_cred[1] != 0), 1);
      s_req[1] = 0;
      repeat (4) step();

      // Backpressure on the DEPTH=4, LATENCY=2 instance.
      pulse_reset();
      s_req = '{1, 0}; s_rdy = '{0, 0};
      stats_clear();
      repeat (10) step();
      check("a.bp_grants", gcnt[0], 4);
      check("a.bp_count", last_cnt[0], 4);
      s_rdy[0] = 1; step();
      s_rdy[0] = 0; stats_clear(); step();
      check("a.bp_regrant", gcnt[0], 1);
      check("a.bp_credit_ret", last_cred[0], 1);
      step();
      check("a.bp_no_regrant", gcnt[0], 1);
      s_req[0] = 0; s_rdy[0] = 1;
      repeat (10) step();

      // Full buffer: injected arrival lands in the slot freed by a simultaneous pop.
      pulse_reset();
      s_req = '{0, 1}; s_rdy = '{0, 0};
      repeat (6) step();
      s_req[1] = 0; s_inj[1] = 1; inj_dat[1] = 8'hC3; s_rdy[1] = 1;
      step();
      s_inj[1] = 0; s_rdy[1] = 0;
      step();
      check("b.fullpp_count", last_cnt[1], 3);
      check("b.fullpp_no_ovf", last_ovf[1], 0);
      s_req[1] = 1; s_rdy[1] = 1;
      repeat (8) step();

      // Overflow: arrival into a full buffer with no pop is dropped and sticky.
      pulse_reset();
      s_req = '{0, 1}; s_rdy = '{0, 0};
      repeat (6) step();
      s_req[1] = 0; s_inj[1] = 1; inj_dat[1] = 8'h99;
      step();
      s_inj[1] = 0;
      step();
      check("b.ovf_set", last_ovf[1], 1);
      check("b.ovf_count", last_cnt[1], 3);
      s_rdy[1] = 1;
      repeat (5) step();
      check("b.ovf_sticky", last_ovf[1], 1);
      check("b.ovf_drained", last_cnt[1], 0);
      pulse_reset();
      step();
      check("b.ovf_cleared", last_ovf[1], 0);

      // Reset mid-stream with three words buffered and one in flight.
      pulse_reset();
      s_req = '{1, 0}; s_rdy = '{0, 0};
      repeat (4) step();
      s_req[0] = 0;
      step();
      sample(0, g, v, d, c, cr, o);
      check("a.mid_pre_count", c, 3);
      check("a.mid_pre_credits", cr, 0);
      pulse_reset();
      sample(0, g, v, d, c, cr, o);
      check("a.mid_post_count", c, 0);
      check("a.mid_post_credits", cr, 4);
      check("a.mid_post_valid", v, 0);
      s_req[0] = 1; s_rdy[0] = 1;
      repeat (10) step();

      // Random traffic on both instances with occasional resets.
      pulse_reset();
      repeat (600) begin
         for (int k = 0; k < 2; k++) begin
            s_req[k] = ($urandom_range(0, 3) != 0);
            s_rdy[k] = ($urandom_range(0, 2) != 0);
         end
         if ($urandom_range(0, 199) == 0) pulse_reset();
         else step();
      end
      s_req = '{0, 0}; s_rdy = '{1, 1};
      repeat (10) step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
